sop_eval_engine: RTL and testbench

Programmable sum-of-products evaluator: a loadable term table (care/value/output-enable per term) drives N_OUT registered Boolean outputs over an N_IN-bit input vector, replacing hard-wired minimised gate networks. A sweep mode walks all 2^N_IN input combinations and reports the minterm count per output, so a programmed, minimised function can be checked against its truth table in-system. It sits between the configuration bus and datapath consumers of Boolean flags.

---
 rtl/sop_eval_engine.sv | 157 +++++++++++++++
 tb/tb_sop_eval_engine.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/sop_eval_engine.sv
// Programmable sum-of-products evaluator with a truth-table sweep
// that counts minterms per output for in-system function checking.
module sop_eval_engine #(
    parameter int N_IN   = 4,
    parameter int N_TERM = 8,
    parameter int N_OUT  = 2,
    localparam int IW    = $clog2(N_TERM),
    localparam int CW    = N_IN + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_we,
    input  logic [IW-1:0]         cfg_idx,
    input  logic [N_IN-1:0]       cfg_care,
    input  logic [N_IN-1:0]       cfg_val,
    input  logic [N_OUT-1:0]      cfg_oe,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_IN-1:0]       in_vec,
    output logic                  out_valid,
    output logic [N_OUT-1:0]      out_f,
    input  logic                  sweep_start,
    output logic                  busy,
    output logic                  done,
    output logic [N_OUT*CW-1:0]   cnt
);

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } state_e;

    state_e state_q, state_d;

    logic [N_IN-1:0]  care_q [N_TERM];
    logic [N_IN-1:0]  care_d [N_TERM];
    logic [N_IN-1:0]  val_q  [N_TERM];
    logic [N_IN-1:0]  val_d  [N_TERM];
    logic [N_OUT-1:0] oe_q   [N_TERM];
    logic [N_OUT-1:0] oe_d   [N_TERM];

    logic [N_IN-1:0]     x_q, x_d;
    logic [N_OUT*CW-1:0] cnt_q, cnt_d;
    logic                out_valid_q, out_valid_d;
    logic [N_OUT-1:0]    out_f_q, out_f_d;

    logic [N_OUT-1:0] f_in;
    logic [N_OUT-1:0] f_sw;
    logic             idx_ok;
    logic             idle;

    // A power-of-two table has no unreachable index to reject.
    if ((2 ** IW) == N_TERM) begin : g_idx_full
        assign idx_ok = 1'b1;
    end else begin : g_idx_part
        assign idx_ok = cfg_idx < IW'(N_TERM);
    end

    assign idle = (state_q == IDLE);

    // Two evaluators share the table: one for requests, one for the sweep.
    always_comb begin
        f_in = '0;
        f_sw = '0;
        for (int j = 0; j < N_TERM; j++) begin
            if (((in_vec ^ val_q[j]) & care_q[j]) == '0) begin
                f_in = f_in | oe_q[j];
            end
            if (((x_q ^ val_q[j]) & care_q[j]) == '0) begin
                f_sw = f_sw | oe_q[j];
            end
        end
    end

    always_comb begin
        care_d = care_q;
        val_d  = val_q;
        oe_d   = oe_q;
        if (cfg_we && idle && idx_ok) begin
            care_d[cfg_idx] = cfg_care;
            val_d[cfg_idx]  = cfg_val;
            oe_d[cfg_idx]   = cfg_oe;
        end
    end

    always_comb begin
        out_valid_d = in_valid && idle;
        out_f_d     = out_f_q;
        if (in_valid && idle) begin
            out_f_d = f_in;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (sweep_start) begin
                    state_d = SWEEP;
                    x_d     = '0;
                    cnt_d   = '0;
                end
            end
            SWEEP: begin
                for (int k = 0; k < N_OUT; k++) begin
                    if (f_sw[k]) begin
                        cnt_d[k*CW +: CW] = cnt_q[k*CW +: CW] + 1'b1;
                    end
                end
                if (&x_q) begin
                    state_d = DONE;
                end else begin
                    x_d = x_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            care_q      <= '{default: '0};
            val_q       <= '{default: '0};
            oe_q        <= '{default: '0};
            x_q         <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_f_q     <= '0;
        end else begin
            state_q     <= state_d;
            care_q      <= care_d;
            val_q       <= val_d;
            oe_q        <= oe_d;
            x_q         <= x_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_f_q     <= out_f_d;
        end
    end

    assign in_ready  = idle;
    assign busy      = (state_q == SWEEP);
    assign done      = (state_q == DONE);
    assign cnt       = cnt_q;
    assign out_valid = out_valid_q;
    assign out_f     = out_f_q;

endmodule

// File: tb/tb_sop_eval_engine.sv
// Scoreboard bench for sop_eval_engine: expected results are queued
// by the stimulus thread and checked by an independent monitor.
module tb_sop_eval_engine;

    logic       clk;
    logic       rst_n;
    logic       cfg_we;
    logic [2:0] cfg_idx;
    logic [3:0] cfg_care;
    logic [3:0] cfg_val;
    logic [1:0] cfg_oe;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_vec;
    logic       out_valid;
    logic [1:0] out_f;
    logic       sweep_start;
    logic       busy;
    logic       done;
    logic [9:0] cnt;

    int n_chk = 0;
    int n_fail = 0;

    logic [1:0] q_f[$];
    string      q_n[$];
    logic [9:0] q_c[$];

    sop_eval_engine #(.N_IN(4), .N_TERM(8), .N_OUT(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_care(cfg_care),
        .cfg_val(cfg_val), .cfg_oe(cfg_oe),
        .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
        .out_valid(out_valid), .out_f(out_f),
        .sweep_start(sweep_start), .busy(busy), .done(done), .cnt(cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: consumes expectations whenever the DUT presents a result.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q_f.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_out_valid: got out_f=%b expected none", out_f);
            end else begin
                logic [1:0] e;
                string nm;
                e  = q_f.pop_front();
                nm = q_n.pop_front();
                chk(nm, int'(out_f), int'(e));
            end
        end
        if (rst_n && done) begin
            if (q_c.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: got cnt=%h expected none", cnt);
            end else begin
                logic [9:0] ec;
                ec = q_c.pop_front();
                chk("sweep_cnt_f1", int'(cnt[4:0]), int'(ec[4:0]));
                chk("sweep_cnt_f2", int'(cnt[9:5]), int'(ec[9:5]));
            end
        end
    end

    task automatic ev(input logic [3:0] v, input logic [1:0] e, input string nm);
        @(negedge clk);
        in_valid = 1'b1;
        in_vec   = v;
        q_f.push_back(e);
        q_n.push_back(nm);
    endtask

    task automatic wr(input logic [2:0] i, input logic [3:0] c,
                      input logic [3:0] v, input logic [1:0] o);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_idx  = i;
        cfg_care = c;
        cfg_val  = v;
        cfg_oe   = o;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        cfg_we   = 1'b0;
    endtask

    task automatic sweep(input logic [4:0] e1, input logic [4:0] e2,
                         input bit wr_mid);
        int busy_n;
        int done_at;
        int rdy_bad;
        busy_n  = 0;
        done_at = 0;
        rdy_bad = 0;
        q_c.push_back({e2, e1});
        @(negedge clk);
        sweep_start = 1'b1;
        for (int n = 1; n <= 40 && done_at == 0; n++) begin
            @(negedge clk);
            sweep_start = 1'b0;
            cfg_we   = wr_mid && (n == 3);
            cfg_idx  = 3'd1;
            cfg_care = 4'b0000;
            cfg_val  = 4'b0000;
            cfg_oe   = 2'b11;
            if (busy) busy_n++;
            if (busy && in_ready) rdy_bad++;
            if (done) done_at = n;
        end
        cfg_we = 1'b0;
        chk("busy_len", busy_n, 16);
        chk("ready_low_in_sweep", rdy_bad, 0);
        chk("done_cycle", done_at, 17);
        @(negedge clk);
        chk("done_one_cycle", int'(done), 0);
        chk("ready_after_sweep", int'(in_ready), 1);
        chk("cnt_hold", int'(cnt), int'({e2, e1}));
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        cfg_we = 1'b0;
        cfg_idx = '0;
        cfg_care = '0;
        cfg_val = '0;
        cfg_oe = '0;
        in_valid = 1'b0;
        in_vec = '0;
        sweep_start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_f", int'(out_f), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_cnt", int'(cnt), 0);

        ev(4'b1111, 2'b00, "empty_eval");
        idle();
        sweep(5'd0, 5'd0, 1'b0);

        // f1 on bit 0, f2 on bit 1
        wr(3'd0, 4'b0101, 4'b0000, 2'b01);
        wr(3'd1, 4'b1101, 4'b0101, 2'b01);
        wr(3'd2, 4'b1110, 4'b1100, 2'b01);
        wr(3'd3, 4'b0011, 4'b0001, 2'b10);
        wr(3'd4, 4'b0110, 4'b0110, 2'b10);
        wr(3'd5, 4'b1010, 4'b1010, 2'b10);
        idle();
        ev(4'b0101, 2'b11, "eval_0101");
        ev(4'b0011, 2'b00, "eval_0011");
        ev(4'b1010, 2'b11, "eval_1010");
        ev(4'b1100, 2'b01, "eval_1100");
        ev(4'b0110, 2'b10, "eval_0110");
        ev(4'b1010, 2'b11, "eval_1010_again");
        idle();
        @(negedge clk);
        chk("out_valid_drop", int'(out_valid), 0);
        chk("out_f_hold", int'(out_f), 3);
        sweep(5'd8, 5'd10, 1'b0);

        // slot 0 rewritten on the same edge as a request
        @(negedge clk);
        in_valid = 1'b1;
        in_vec   = 4'b0000;
        q_f.push_back(2'b01);
        q_n.push_back("same_edge_old_term");
        cfg_we   = 1'b1;
        cfg_idx  = 3'd0;
        cfg_care = 4'b1111;
        cfg_val  = 4'b1111;
        cfg_oe   = 2'b10;
        @(negedge clk);
        cfg_we = 1'b0;
        in_vec = 4'b0000;
        q_f.push_back(2'b00);
        q_n.push_back("next_new_term");
        idle();
        sweep(5'd4, 5'd10, 1'b1);
        sweep(5'd4, 5'd10, 1'b0);

        wr(3'd7, 4'b0000, 4'b0000, 2'b11);
        idle();
        sweep(5'd16, 5'd16, 1'b0);

        // reset five cycles into a sweep
        @(negedge clk);
        sweep_start = 1'b1;
        @(negedge clk);
        sweep_start = 1'b0;
        repeat (4) @(negedge clk);
        chk("busy_before_rst", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_cnt", int'(cnt), 0);
        chk("mid_rst_out_f", int'(out_f), 0);
        @(negedge clk);
        rst_n = 1'b1;
        ev(4'b1111, 2'b00, "eval_after_rst");
        idle();
        sweep(5'd0, 5'd0, 1'b0);

        repeat (2) @(negedge clk);
        chk("f_queue_drained", q_f.size(), 0);
        chk("cnt_queue_drained", q_c.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
